led_breath_pwm: RTL and testbench
=================================

Name: led_breath_pwm

Overview:
- Downstream consumer of the LED tick generator's active-low one-cycle strobe, which fires once every 25 000 Clk50M cycles (2 kHz).
- Uses that tick as a time base to step a triangle-wave "breathing" phase.
- Drives NUM_CH LED outputs with phase-staggered PWM, producing a rolling breathing pattern on the 8-channel LED bank.
- The PWM comparator runs at full Clk50M rate. Only the ramp advances on ticks.

Parameters:
- PWM_W, 8, duty resolution in bits. PWM_MAX = 2^PWM_W-1.
- STEP_TICKS, 4, number of upstream ticks per phase step (≥1).
- NUM_CH, 8, number of LED channels. Must be a power of 2 and ≤ 2^(PWM_W+1).
- LED_ACTIVE_LOW, 1, 1 means a lit LED is driven 0.

Ports:
- Clk50M  in  1  system clock, 50 MHz
- Rst_n  in  1  asynchronous active-low reset
- Tick_n  in  1  active-low strobe from upstream tick generator, synchronous to Clk50M
- En  in  1  run request, level-sensitive
- Led  out  NUM_CH  LED drive (registered)
- Duty  out  PWM_W  current duty of channel 0
- Dir  out  1  1 = ramping up, 0 = ramping down
- Busy  out  1  1 when state is not IDLE

Behaviour:
- Reset: Rst_n is asynchronous, active-low; clock is Clk50M.
- Reset values: Led = all-off level (all 1s when LED_ACTIVE_LOW=1); Duty = 0; Dir = 1; Busy = 0; state IDLE; ph = 0; div_cnt = 0; pwm_cnt = 0; tick_prev = 1.
- Tick detect: a tick is counted when tick_prev=1 and Tick_n=0 (falling edge). A Tick_n held low for N cycles counts exactly once.
- Divider: div_cnt runs 0..STEP_TICKS-1 and advances only on a counted tick while state ≠ IDLE. At STEP_TICKS-1 it issues step, then returns to 0.
- Phase: ph is PWM_W+1 bits and increments by 1 on step, wrapping modulo 2^(PWM_W+1).
- Triangle: tri(p) = p[MSB] ? ~p[PWM_W-1:0] : p[PWM_W-1:0].
- Channel i phase: ph + i·(2^(PWM_W+1)/NUM_CH), taken modulo (natural wrap). Its duty is tri() of that phase.
- Duty = tri(ph) and Dir = ~ph[MSB]; both combinational from ph.
- PWM: pwm_cnt counts 0..PWM_MAX-1 and wraps (period PWM_MAX cycles). A channel is lit when pwm_cnt < duty_i.
  - duty 0 gives always off.
  - duty PWM_MAX gives always on.
- Led is registered one cycle after the compare.
- FSM:
  - IDLE: ph and div_cnt are held at 0; Led all off. On En=1, go to RUN on the next edge.
  - RUN: stepping as above. On En=0, go to STOP.
  - STOP: stepping continues. When a step makes ph wrap to 0, go to IDLE on that edge (channel 0 fades out cleanly). If En returns to 1 in STOP, go back to RUN with no phase disturbance.
- Simultaneous events:
  - A tick on the same cycle as the IDLE→RUN transition is ignored.
  - A tick on the cycle STOP reaches ph=0 is consumed by that step.
- Reset asserted mid-operation returns every register to its reset value immediately.

Optional Feature:
- Macro: LED_BREATH_GAMMA_EN.
  - Defined: each channel duty is (tri·tri)>>PWM_W, a 2·PWM_W-bit product truncated, giving a perceptual ramp. Duty also reports the mapped value. tri=PWM_MAX maps to PWM_MAX-1, which is accepted.
  - Undefined: linear duty = tri. No multipliers are inferred.

Decomposition:
- Package led_pkg holds:
  - state enum ST_IDLE / ST_RUN / ST_STOP
  - PWM_MAX and CH_OFFSET constants
  - function tri_wave()
- Natural sub-module: led_pwm_ch. Per channel it takes the duty, the shared pwm_cnt and the polarity parameter, and produces one registered Led bit. It is instantiated NUM_CH times by a generate loop.

Test Plan:
- Reset check: Rst_n=0 while Tick_n toggles → Led=8'hFF, Duty=0, Dir=1, Busy=0. Release reset with En=0, 10 ticks → nothing changes.
- Linear ramp: STEP_TICKS=1, En=1, 3 ticks → Duty=3. Led[0] is 0 for exactly 3 of every 255 cycles; Led[1] (offset 64) has Duty 67.
- Stuck-low tick: Tick_n held low 10 cycles → counted once; Duty increments by 1 only.
- Peak and reversal: 255 ticks → Duty=255 and Led[0] constantly 0. Tick 256 → Dir=0, Duty=255. Tick 257 → Duty=254.
- Stagger: at ph=0, channel 7 phase is 448 → duty 63. Wrap check at ph=511 → channel 0 duty 0, channel 1 duty 63.
- Stop and reset mid-run:
  - En=0 at Duty=100, Dir=1 → Busy stays 1, ramp continues through 255 down to 0, then IDLE and Led=8'hFF.
  - Rst_n pulsed mid-RUN → immediate reset values.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types, default constants and the triangle-wave helper for the LED breathing PWM.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } led_state_e;

    localparam int unsigned PWM_W_DEF  = 8;
    localparam int unsigned NUM_CH_DEF = 8;
    localparam int unsigned PWM_MAX    = (1 << PWM_W_DEF) - 1;
    localparam int unsigned CH_OFFSET  = (1 << (PWM_W_DEF + 1)) / NUM_CH_DEF;

    // Triangle of a (w+1)-bit phase: rising half passes the low bits, falling half inverts them.
    function automatic logic [31:0] tri_wave(input logic [31:0] p, input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return p[w] ? (~p & mask) : (p & mask);
    endfunction

endpackage

// File: rtl/led_pwm_ch.sv
// One PWM channel: compares the shared counter with this channel's duty and registers the LED bit.
module led_pwm_ch #(
    parameter int unsigned PWM_W          = 8,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic             Clk50M,
    input  logic             Rst_n,
    input  logic [PWM_W-1:0] duty,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led
);

    logic lit;

    // Lit while the counter is below the duty; duty 0 never lights, duty PWM_MAX always does.
    always_comb begin
        lit = (pwm_cnt < duty);
    end

    // Register the drive level, applying the board's LED polarity.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            led <= LED_ACTIVE_LOW;
        end else begin
            led <= LED_ACTIVE_LOW ? ~lit : lit;
        end
    end

endmodule

// File: rtl/led_breath_pwm.sv
// Breathing LED bank: upstream 2 kHz ticks step a triangle phase, channels are phase-staggered PWM.
// Optional build macro LED_BREATH_GAMMA_EN squares each duty for a perceptual ramp.
module led_breath_pwm
    import led_pkg::*;
#(
    parameter int unsigned PWM_W          = PWM_W_DEF,
    parameter int unsigned STEP_TICKS     = 4,
    parameter int unsigned NUM_CH         = NUM_CH_DEF,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic              Clk50M,
    input  logic              Rst_n,
    input  logic              Tick_n,
    input  logic              En,
    output logic [NUM_CH-1:0] Led,
    output logic [PWM_W-1:0]  Duty,
    output logic              Dir,
    output logic              Busy
);

    localparam int unsigned PH_W    = PWM_W + 1;
    localparam int unsigned PH_OFF  = (1 << PH_W) / NUM_CH;
    localparam int unsigned DIV_W   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int unsigned PWM_TOP = (1 << PWM_W) - 2;  // last count, so period is PWM_MAX

    led_state_e        state;
    logic [PH_W-1:0]   ph;
    logic [PH_W-1:0]   ph_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic              tick_prev;
    logic              tick;
    logic              step;

    // Falling-edge tick detect and divider terminal count.
    always_comb begin
        tick    = tick_prev & ~Tick_n;
        step    = tick && (div_cnt == DIV_W'(STEP_TICKS - 1));
        ph_next = ph + PH_W'(1);
    end

    // Run/stop state machine with the tick divider and the phase accumulator.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            ph        <= '0;
            div_cnt   <= '0;
            tick_prev <= 1'b1;
        end else begin
            tick_prev <= Tick_n;
            unique case (state)
                ST_IDLE: begin
                    // A tick coinciding with the start request is deliberately dropped.
                    ph      <= '0;
                    div_cnt <= '0;
                    if (En) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (step) begin
                        div_cnt <= '0;
                        ph      <= ph_next;
                    end else if (tick) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (state == ST_RUN) begin
                        if (!En) begin
                            state <= ST_STOP;
                        end
                    end else if (En) begin
                        state <= ST_RUN;
                    end else if (step && (ph_next == '0)) begin
                        // Channel 0 has just faded to zero, so the bank goes dark cleanly.
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running PWM counter shared by all channels.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_W'(PWM_TOP)) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // Status outputs decoded from the phase and state registers.
    always_comb begin
        Dir  = ~ph[PH_W-1];
        Busy = (state != ST_IDLE);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [PH_W-1:0]  ph_ch;
        logic [PWM_W-1:0] tri_ch;
        logic [PWM_W-1:0] duty_ch;
        logic [PWM_W-1:0] duty_gated;

        assign ph_ch  = ph + PH_W'(i * PH_OFF);
        assign tri_ch = PWM_W'(tri_wave(32'(ph_ch), PWM_W));

`ifdef LED_BREATH_GAMMA_EN
        logic [2*PWM_W-1:0] sq;
        assign sq      = tri_ch * tri_ch;
        assign duty_ch = sq[2*PWM_W-1:PWM_W];
`else
        assign duty_ch = tri_ch;
`endif

        // Idle forces every channel dark even though staggered phases are non-zero.
        assign duty_gated = (state == ST_IDLE) ? '0 : duty_ch;

        if (i == 0) begin : g_duty
            assign Duty = duty_ch;
        end

        led_pwm_ch #(
            .PWM_W         (PWM_W),
            .LED_ACTIVE_LOW(LED_ACTIVE_LOW)
        ) u_ch (
            .Clk50M (Clk50M),
            .Rst_n  (Rst_n),
            .duty   (duty_gated),
            .pwm_cnt(pwm_cnt),
            .led    (Led[i])
        );
    end

endmodule

// File: tb/tb_led_breath_pwm.sv
// Directed bench for led_breath_pwm with STEP_TICKS=1 so each tick moves the phase by one.
module tb_led_breath_pwm;
    import led_pkg::*;

    logic       Clk50M;
    logic       Rst_n;
    logic       Tick_n;
    logic       En;
    logic [7:0] Led;
    logic [7:0] Duty;
    logic       Dir;
    logic       Busy;

    int errors = 0;
    int checks = 0;

    led_breath_pwm #(
        .PWM_W         (8),
        .STEP_TICKS    (1),
        .NUM_CH        (8),
        .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk50M(Clk50M),
        .Rst_n (Rst_n),
        .Tick_n(Tick_n),
        .En    (En),
        .Led   (Led),
        .Duty  (Duty),
        .Dir   (Dir),
        .Busy  (Busy)
    );

    initial Clk50M = 1'b0;
    always #10 Clk50M = ~Clk50M;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One-cycle low strobe, launched and finished on falling edges.
    task automatic pulse_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            Tick_n = 1'b0;
            @(negedge Clk50M);
            Tick_n = 1'b1;
            @(negedge Clk50M);
        end
    endtask

    // Counts lit cycles (Led bit low) on one channel after letting the register settle.
    task automatic count_lit(input int ch, input int ncyc, output int cnt);
        cnt = 0;
        repeat (2) @(negedge Clk50M);
        for (int k = 0; k < ncyc; k++) begin
            if (Led[ch] == 1'b0) cnt++;
            @(negedge Clk50M);
        end
    endtask

    int cnt;

    initial begin
        Rst_n  = 1'b0;
        Tick_n = 1'b1;
        En     = 1'b0;

        // Reset held while the tick line toggles.
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk50M);
            Tick_n = ~Tick_n;
        end
        Tick_n = 1'b1;
        @(negedge Clk50M);
        check_eq("rst_led", 32'(Led), 32'hFF);
        check_eq("rst_duty", 32'(Duty), 0);
        check_eq("rst_dir", 32'(Dir), 1);
        check_eq("rst_busy", 32'(Busy), 0);

        // Out of reset but disabled: ticks have no effect.
        Rst_n = 1'b1;
        @(negedge Clk50M);
        pulse_ticks(10);
        check_eq("idle_duty", 32'(Duty), 0);
        check_eq("idle_busy", 32'(Busy), 0);
        check_eq("idle_led", 32'(Led), 32'hFF);

        // Start with a tick on the same cycle; that tick is dropped.
        En     = 1'b1;
        Tick_n = 1'b0;
        @(negedge Clk50M);
        Tick_n = 1'b1;
        @(negedge Clk50M);
        check_eq("start_busy", 32'(Busy), 1);
        check_eq("start_tick_ignored", 32'(Duty), 0);

        // Linear ramp.
        pulse_ticks(3);
        check_eq("ramp_duty3", 32'(Duty), 3);
        check_eq("ramp_dir", 32'(Dir), 1);
        count_lit(0, 255, cnt);
        check_eq("ramp_led0_lit", 32'(cnt), 3);
        count_lit(1, 255, cnt);
        check_eq("ramp_led1_lit", 32'(cnt), 3 + CH_OFFSET);
        count_lit(7, 255, cnt);
        check_eq("ramp_led7_lit", 32'(cnt), 60);

        // Tick held low for 10 cycles counts once.
        Tick_n = 1'b0;
        repeat (10) @(negedge Clk50M);
        Tick_n = 1'b1;
        @(negedge Clk50M);
        check_eq("stuck_tick", 32'(Duty), 4);

        // Peak and reversal.
        pulse_ticks(251);
        check_eq("peak_duty", 32'(Duty), PWM_MAX);
        check_eq("peak_dir", 32'(Dir), 1);
        count_lit(0, 300, cnt);
        check_eq("peak_led0_on", 32'(cnt), 300);
        pulse_ticks(1);
        check_eq("rev_dir", 32'(Dir), 0);
        check_eq("rev_duty255", 32'(Duty), 255);
        pulse_ticks(1);
        check_eq("rev_duty254", 32'(Duty), 254);

        // ph = 511: channel 0 dark, channel 1 wraps to phase 63.
        pulse_ticks(254);
        check_eq("wrap_duty", 32'(Duty), 0);
        count_lit(0, 255, cnt);
        check_eq("wrap_led0_lit", 32'(cnt), 0);
        count_lit(1, 255, cnt);
        check_eq("wrap_led1_lit", 32'(cnt), 63);

        // ph = 0: channel 7 at phase 448 gives duty 63.
        pulse_ticks(1);
        check_eq("ph0_dir", 32'(Dir), 1);
        count_lit(7, 255, cnt);
        check_eq("ph0_led7_lit", 32'(cnt), 63);

        // Stop at duty 100 while ramping up; it runs the full cycle down to zero.
        pulse_ticks(100);
        check_eq("stop_at100", 32'(Duty), 100);
        En = 1'b0;
        @(negedge Clk50M);
        check_eq("stop_busy", 32'(Busy), 1);
        pulse_ticks(200);
        check_eq("stop_duty300", 32'(Duty), 211);
        // Brief re-enable in STOP must not disturb the phase.
        En = 1'b1;
        @(negedge Clk50M);
        En = 1'b0;
        @(negedge Clk50M);
        check_eq("reen_duty", 32'(Duty), 211);
        check_eq("reen_busy", 32'(Busy), 1);
        pulse_ticks(211);
        check_eq("stop_duty511", 32'(Duty), 0);
        check_eq("stop_busy511", 32'(Busy), 1);
        pulse_ticks(1);
        check_eq("stop_idle_busy", 32'(Busy), 0);
        check_eq("stop_idle_dir", 32'(Dir), 1);
        repeat (2) @(negedge Clk50M);
        check_eq("stop_idle_led", 32'(Led), 32'hFF);

        // Reset pulsed mid-run clears everything immediately.
        En = 1'b1;
        repeat (2) @(negedge Clk50M);
        pulse_ticks(5);
        check_eq("run5_duty", 32'(Duty), 5);
        #3;
        Rst_n = 1'b0;
        #1;
        check_eq("mid_rst_led", 32'(Led), 32'hFF);
        check_eq("mid_rst_duty", 32'(Duty), 0);
        check_eq("mid_rst_dir", 32'(Dir), 1);
        check_eq("mid_rst_busy", 32'(Busy), 0);
        @(negedge Clk50M);
        Rst_n = 1'b1;
        En    = 1'b0;
        repeat (2) @(negedge Clk50M);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
